// File: rtl/fp_vector_checker.sv
// Floating-point test-vector checker: issues each vector to a DUT,
// compares the response against the reference and keeps pass/fail statistics.
module fp_vector_checker #(
    parameter int EXP_W        = 8,
    parameter int MAN_W        = 23,
    parameter int XLEN         = 1 + EXP_W + MAN_W,
    parameter int TIMEOUT      = 256,
    parameter bit STOP_ON_FAIL = 1'b1,
    parameter bit NAN_MASK     = 1'b1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            vec_valid,
    output logic            vec_ready,
    input  logic [XLEN-1:0] vec_a,
    input  logic [XLEN-1:0] vec_b,
    input  logic [XLEN-1:0] vec_c,
    input  logic [2:0]      vec_rm,
    input  logic [3:0]      vec_op,
    input  logic            vec_last,
    input  logic [XLEN-1:0] vec_exp_result,
    input  logic [4:0]      vec_exp_flags,
    output logic            dut_enable,
    output logic [XLEN-1:0] dut_data1,
    output logic [XLEN-1:0] dut_data2,
    output logic [XLEN-1:0] dut_data3,
    output logic [2:0]      dut_rm,
    output logic [3:0]      dut_op,
    input  logic            dut_ready,
    input  logic [XLEN-1:0] dut_result,
    input  logic [4:0]      dut_flags,
    output logic [31:0]     pass_count,
    output logic [31:0]     fail_count,
    output logic            done,
    output logic            fail,
    output logic            timeout,
    output logic [31:0]     fail_index,
    output logic [XLEN-1:0] fail_result_diff,
    output logic [4:0]      fail_flags_diff
);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_CHECK, S_DONE, S_HALT
    } state_e;

    localparam logic [XLEN-1:0] QNAN =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [31:0] TMAX = 32'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [XLEN-1:0] a_q, b_q, c_q, exp_q, res_q;
    logic [2:0]      rm_q;
    logic [3:0]      op_q;
    logic [4:0]      efl_q, flg_q;
    logic            last_q;
    logic [31:0]     timer_q;
    logic [31:0]     pass_q, pass_d, failc_q, failc_d;
    logic [31:0]     idx_q, fidx_q;
    logic [XLEN-1:0] frd_q;
    logic [4:0]      ffd_q;
    logic            fseen_q, failf_q, tout_q;

    logic            accept, check, tout_hit, mism;
    logic [XLEN-1:0] rdiff;
    logic [4:0]      fdiff;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign vec_ready = (state_q == S_IDLE) && !reset;
    assign accept    = vec_valid && vec_ready;
    assign check     = (state_q == S_CHECK);

    always_comb begin
        state_d  = state_q;
        pass_d   = pass_q;
        failc_d  = failc_q;
        tout_hit = 1'b0;
        rdiff    = exp_q ^ res_q;
        // A canonical NaN from the DUT matches any reference NaN payload/sign
        if (NAN_MASK && (res_q == QNAN)) begin
            rdiff[XLEN-1]    = 1'b0;
            rdiff[MAN_W-2:0] = '0;
        end
        fdiff = efl_q ^ flg_q;
        mism  = (rdiff != '0) || (fdiff != '0);
        unique case (state_q)
            S_IDLE:  if (accept) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (dut_ready) begin
                    state_d = S_CHECK;
                end else if (timer_q + 32'd1 == TMAX) begin
                    state_d  = S_HALT;
                    tout_hit = 1'b1;
                end
            end
            S_CHECK: begin
                if (mism && STOP_ON_FAIL) state_d = S_HALT;
                else if (last_q)          state_d = S_DONE;
                else                      state_d = S_IDLE;
            end
            S_DONE, S_HALT: state_d = state_q;
            default: state_d = S_IDLE;
        endcase
        if (check) begin
            if (mism) failc_d = sat_inc(failc_q);
            else      pass_d  = sat_inc(pass_q);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            rm_q    <= '0;
            op_q    <= '0;
            last_q  <= 1'b0;
            exp_q   <= '0;
            efl_q   <= '0;
            res_q   <= '0;
            flg_q   <= '0;
            timer_q <= '0;
            pass_q  <= '0;
            failc_q <= '0;
            idx_q   <= '0;
            fidx_q  <= '0;
            frd_q   <= '0;
            ffd_q   <= '0;
            fseen_q <= 1'b0;
            failf_q <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            failc_q <= failc_d;
            failf_q <= (failc_d != '0);
            if (accept) begin
                a_q    <= vec_a;
                b_q    <= vec_b;
                c_q    <= vec_c;
                rm_q   <= vec_rm;
                op_q   <= vec_op;
                last_q <= vec_last;
                exp_q  <= vec_exp_result;
                efl_q  <= vec_exp_flags;
            end
            if (state_q == S_ISSUE) begin
                timer_q <= '0;
            end else if (state_q == S_WAIT) begin
                if (dut_ready) begin
                    res_q <= dut_result;
                    flg_q <= dut_flags;
                end else begin
                    timer_q <= timer_q + 32'd1;
                end
            end
            if (tout_hit) tout_q <= 1'b1;
            if (check) begin
                idx_q <= sat_inc(idx_q);
                if (mism && !fseen_q) begin
                    fseen_q <= 1'b1;
                    fidx_q  <= idx_q;
                    frd_q   <= rdiff;
                    ffd_q   <= fdiff;
                end
            end
        end
    end

    assign dut_enable       = (state_q == S_ISSUE);
    assign dut_data1        = a_q;
    assign dut_data2        = b_q;
    assign dut_data3        = c_q;
    assign dut_rm           = rm_q;
    assign dut_op           = op_q;
    assign pass_count       = pass_q;
    assign fail_count       = failc_q;
    assign done             = (state_q == S_DONE) || (state_q == S_HALT);
    assign fail             = failf_q;
    assign timeout          = tout_q;
    assign fail_index       = fidx_q;
    assign fail_result_diff = frd_q;
    assign fail_flags_diff  = ffd_q;

endmodule

// File: doc/fp_vector_checker.md
FP_VECTOR_CHECKER -- requirements
Module: fp_vector_checker

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent width; MAN_W, default 23, mantissa width; XLEN = 1+EXP_W+MAN_W (derived).
REQ-002 SHALL have parameter TIMEOUT, default 256, maximum cycles to wait for dut_ready; STOP_ON_FAIL, default 1, halt on first mismatch; NAN_MASK, default 1, relax payload/sign compare on canonical NaN.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clock  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-004 vec_valid  in  1; vec_ready  out  1  vector handshake.
REQ-005 vec_a, vec_b, vec_c  in  XLEN  operands; vec_rm  in  3  rounding mode; vec_op  in  4  operation select; vec_last  in  1  final vector.
REQ-006 vec_exp_result  in  XLEN; vec_exp_flags  in  5  reference result/flags.
REQ-007 dut_enable  out  1; dut_data1/2/3  out  XLEN; dut_rm  out  3; dut_op  out  4  DUT request.
REQ-008 dut_ready  in  1; dut_result  in  XLEN; dut_flags  in  5  DUT response.
REQ-009 pass_count, fail_count  out  32; done, fail, timeout  out  1; fail_index  out  32; fail_result_diff  out  XLEN; fail_flags_diff  out  5.

Function
REQ-010 FSM states SHALL be IDLE, ISSUE, WAIT, CHECK, DONE, HALT.
REQ-011 IDLE: vec_ready=1; on vec_valid&vec_ready capture all vec_* fields -> ISSUE; vec_ready=0 in every other state.
REQ-012 ISSUE: dut_enable=1 for exactly one cycle, dut_* driven from captured fields -> WAIT; wait timer cleared.
REQ-013 dut_data*/rm/op SHALL hold captured values from ISSUE until next capture; dut_enable=0 outside ISSUE.
REQ-014 WAIT: dut_ready=1 -> latch dut_result/dut_flags -> CHECK; else timer+1; timer reaching TIMEOUT-1 without ready -> HALT, timeout=1.
REQ-015 dut_ready SHALL be ignored outside WAIT (including the ISSUE cycle).
REQ-016 CHECK: rdiff = exp_result XOR dut_result; fdiff = exp_flags XOR dut_flags.
REQ-017 If NAN_MASK=1 and dut_result is canonical qNaN (sign 0, exponent all ones, mantissa MSB 1, rest 0), rdiff sign bit and mantissa bits [MAN_W-2:0] SHALL be cleared before compare.
REQ-018 rdiff==0 and fdiff==0 -> pass_count+1; else fail_count+1.
REQ-019 First mismatch only SHALL latch fail_index (0-based accepted-vector index), fail_result_diff, fail_flags_diff; later mismatches do not overwrite.
REQ-020 After CHECK: mismatch and STOP_ON_FAIL=1 -> HALT; else captured last=1 -> DONE; else -> IDLE.
REQ-021 DONE and HALT SHALL be terminal until reset; done=1 in both; fail = (fail_count!=0) registered.
REQ-022 Counters SHALL saturate at 32'hFFFFFFFF.
REQ-023 Latency: accept at cycle N, dut_enable at N+1, earliest WAIT ready N+2, CHECK N+3, vec_ready again N+4.

Reset
REQ-024 On reset: state IDLE, all counters/indices/diffs 0, done/fail/timeout/dut_enable 0, dut_* 0, vec_ready 0 during reset cycle and 1 in first IDLE cycle.
REQ-025 Reset in any state, including WAIT, SHALL abort the vector; a dut_ready arriving after reset SHALL not update counts.

Verification
REQ-026 Vector a=3F800000 b=40000000 expect 3F000000 flags 00, last=1; DUT returns 3F000000/00 3 cycles after enable -> pass_count=1, fail=0, done=1.
REQ-027 NaN mask: expect FFC00001 flags 10, DUT 7FC00000/10 -> pass; same with NAN_MASK=0 -> fail, fail_result_diff=80000001.
REQ-028 STOP_ON_FAIL=1, third vector expects flags 01, DUT 00 -> fail_count=1, fail_index=2, fail_flags_diff=01, HALT, vec_ready held 0.
REQ-029 STOP_ON_FAIL=0, 4 vectors, 2nd and 4th mismatch -> pass_count=2, fail_count=2, fail_index=1, done=1.
REQ-030 TIMEOUT=16, dut_ready never asserted -> timeout=1 and done=1 16 cycles after dut_enable; counts unchanged.
REQ-031 Reset asserted in WAIT, dut_ready pulsed next cycle -> all outputs at reset values, pass_count=fail_count=0.
